// File: rtl/grf_hazard_ctrl.sv
// GPR scoreboard for the 5-stage pipe: tracks E/M/W writers, drives D stall and D/E forward selects.
// Optional MDU_STALL_EN adds an MDU busy counter that also stalls D-stage MDU/HI/LO users.
module grf_hazard_ctrl #(
    parameter int unsigned MDU_LAT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic       d_wr,
    input  logic [4:0] d_a3,
    input  logic [1:0] d_tnew,
`ifdef MDU_STALL_EN
    input  logic       md_start,
    input  logic       d_md,
`endif
    output logic       stall,
    output logic [1:0] d_fwd_rs,
    output logic [1:0] d_fwd_rt,
    output logic [1:0] e_fwd_rs,
    output logic [1:0] e_fwd_rt
);

    typedef enum logic [1:0] {
        SRC_GRF = 2'd0,
        SRC_E   = 2'd1,
        SRC_M   = 2'd2,
        SRC_W   = 2'd3
    } src_t;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [4:0] a3;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tnew;
    } entry_t;

    typedef struct packed {
        logic haz;
        src_t sel;
    } res_t;

    entry_t r_e, r_m, r_w;
    res_t   w_d_rs, w_d_rt;

    function automatic logic hit(input entry_t en, input logic [4:0] s);
        return en.valid && en.wr && (en.a3 == s) && (s != '0);
    endfunction

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == '0) ? '0 : t - 2'd1;
    endfunction

    // Youngest matching writer decides both the hazard and the forward source.
    function automatic res_t resolve(input entry_t e, input entry_t m, input entry_t w,
                                     input logic use_e, input logic [4:0] s,
                                     input logic [1:0] tuse);
        res_t   r;
        entry_t win;
        logic   found;
        src_t   stage;
        r.haz = 1'b0;
        r.sel = SRC_GRF;
        win   = '0;
        found = 1'b0;
        stage = SRC_GRF;
        if (use_e && hit(e, s)) begin
            win = e; found = 1'b1; stage = SRC_E;
        end else if (hit(m, s)) begin
            win = m; found = 1'b1; stage = SRC_M;
        end else if (hit(w, s)) begin
            win = w; found = 1'b1; stage = SRC_W;
        end
        if (found) begin
            r.haz = (tuse != 2'd3) && (win.tnew > tuse);
            if (win.tnew == '0) r.sel = stage;
        end
        return r;
    endfunction

`ifdef MDU_STALL_EN
    localparam int unsigned BW = (MDU_LAT < 1) ? 1 : $clog2(MDU_LAT + 1);
    logic [BW-1:0] r_busy;
    logic          w_md_stall;

    always_ff @(posedge clk) begin
        if (rst)                r_busy <= '0;
        else if (md_start)      r_busy <= BW'(MDU_LAT);
        else if (r_busy != '0)  r_busy <= r_busy - 1'b1;
    end

    assign w_md_stall = d_md && (md_start || (r_busy != '0));
`else
    logic w_md_stall;
    assign w_md_stall = 1'b0;
`endif

    always_comb begin
        w_d_rs   = resolve(r_e, r_m, r_w, 1'b1, d_rs, d_tuse_rs);
        w_d_rt   = resolve(r_e, r_m, r_w, 1'b1, d_rt, d_tuse_rt);
        stall    = d_valid && (w_d_rs.haz || w_d_rt.haz || w_md_stall);
        d_fwd_rs = w_d_rs.sel;
        d_fwd_rt = w_d_rt.sel;
        e_fwd_rs = resolve(r_e, r_m, r_w, 1'b0, r_e.rs, 2'd3).sel;
        e_fwd_rt = resolve(r_e, r_m, r_w, 1'b0, r_e.rt, 2'd3).sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e <= '0;
            r_m <= '0;
            r_w <= '0;
        end else begin
            r_w      <= r_m;
            r_w.tnew <= dec_sat(r_m.tnew);
            r_m      <= r_e;
            r_m.tnew <= dec_sat(r_e.tnew);
            if (stall) begin
                r_e <= '0;
            end else begin
                r_e.valid <= d_valid;
                r_e.wr    <= d_wr && (d_a3 != '0);
                r_e.a3    <= d_a3;
                r_e.rs    <= d_rs;
                r_e.rt    <= d_rt;
                r_e.tnew  <= d_tnew;
            end
        end
    end

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Self-checking bench for grf_hazard_ctrl: directed pipeline scenarios plus random traffic
// checked against an age-based history model.
module tb_grf_hazard_ctrl;

    localparam int MDU_LAT = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_wr;
    logic       stall;
    logic [1:0] d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt;
`ifdef MDU_STALL_EN
    logic       md_start, d_md;
`endif

    logic [8:0] outs;
    assign outs = {stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    grf_hazard_ctrl #(.MDU_LAT(MDU_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .d_valid  (d_valid),
        .d_rs     (d_rs),
        .d_rt     (d_rt),
        .d_tuse_rs(d_tuse_rs),
        .d_tuse_rt(d_tuse_rt),
        .d_wr     (d_wr),
        .d_a3     (d_a3),
        .d_tnew   (d_tnew),
`ifdef MDU_STALL_EN
        .md_start (md_start),
        .d_md     (d_md),
`endif
        .stall    (stall),
        .d_fwd_rs (d_fwd_rs),
        .d_fwd_rt (d_fwd_rt),
        .e_fwd_rs (e_fwd_rs),
        .e_fwd_rt (e_fwd_rt)
    );

    // History of issued instructions: index = age in cycles since entering E (0=E, 1=M, 2=W).
    typedef struct {
        bit       v;
        bit       wr;
        bit [4:0] a3;
        bit [4:0] rs;
        bit [4:0] rt;
        int       tnew;
    } ins_t;

    ins_t h[3];
    int   cyc     = 0;
    int   md_free = 0;

    function automatic ins_t empty_ins();
        ins_t x;
        x.v = 0; x.wr = 0; x.a3 = 0; x.rs = 0; x.rt = 0; x.tnew = 0;
        return x;
    endfunction

    function automatic void look(input int first, input logic [4:0] s, input logic [1:0] tuse,
                                 output bit haz, output logic [1:0] sel);
        haz = 0;
        sel = 2'd0;
        for (int i = first; i < 3; i++) begin
            if (h[i].v && h[i].wr && h[i].a3 != 0 && h[i].a3 == s && s != 0) begin
                int ready;
                ready = h[i].tnew - i;
                if (ready < 0) ready = 0;
                haz = (tuse != 2'd3) && (ready > int'(tuse));
                sel = (ready == 0) ? 2'(i + 1) : 2'd0;
                return;
            end
        end
    endfunction

    function automatic logic [8:0] model_out();
        bit hrs, hrt, hx;
        bit md;
        logic [1:0] srs, srt, ers, ert;
        look(0, d_rs, d_tuse_rs, hrs, srs);
        look(0, d_rt, d_tuse_rt, hrt, srt);
        look(1, h[0].rs, 2'd3, hx, ers);
        look(1, h[0].rt, 2'd3, hx, ert);
        md = 0;
`ifdef MDU_STALL_EN
        md = d_md && (md_start || cyc < md_free);
`endif
        return {d_valid && (hrs || hrt || md), srs, srt, ers, ert};
    endfunction

    task automatic drv(input bit v, input logic [4:0] rs, input logic [1:0] tu_rs,
                       input logic [4:0] rt, input logic [1:0] tu_rt,
                       input bit wr, input logic [4:0] a3, input logic [1:0] tn);
        d_valid = v; d_rs = rs; d_tuse_rs = tu_rs; d_rt = rt; d_tuse_rt = tu_rt;
        d_wr = wr; d_a3 = a3; d_tnew = tn;
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 3, 0, 3, 0, 0, 0);
    endtask

    // Advance one clock, keeping the history model in step with the edge.
    task automatic tick();
        logic [8:0] ex;
        ex = model_out();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) h[i] = empty_ins();
            md_free = 0;
        end else begin
            h[2] = h[1];
            h[1] = h[0];
            if (ex[8]) begin
                h[0] = empty_ins();
            end else begin
                h[0].v = d_valid; h[0].wr = d_wr; h[0].a3 = d_a3;
                h[0].rs = d_rs; h[0].rt = d_rt; h[0].tnew = int'(d_tnew);
            end
`ifdef MDU_STALL_EN
            if (md_start) md_free = cyc + 1 + MDU_LAT;
`endif
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic flush();
        idle();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drv(1, 5, 0, 5, 0, 1, 5, 2);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            total++;
            if (outs !== 9'b0) begin
                bad++;
                $display("FAIL reset_idle[%0d] got=%b exp=%b", i, outs, 9'b0);
            end
            tick();
        end
    endtask

    task automatic test_alu_use();
        drv(1, 0, 3, 0, 3, 1, 3, 1);
        tick();
        drv(1, 3, 1, 0, 3, 0, 0, 0);
        total++;
        if (outs !== 9'b0_00_00_00_00) begin
            bad++; $display("FAIL alu_d_nostall got=%b exp=%b", outs, 9'b0_00_00_00_00);
        end
        tick();
        idle();
        total++;
        if (outs !== 9'b0_00_00_10_00) begin
            bad++; $display("FAIL alu_e_fwd_m got=%b exp=%b", outs, 9'b0_00_00_10_00);
        end
        flush();
    endtask

    task automatic test_load_use();
        // Branch-style consumer: needs the value in D
        drv(1, 0, 3, 0, 3, 1, 5, 2);
        tick();
        drv(1, 5, 0, 0, 3, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (outs !== 9'b1_00_00_00_00) begin
                bad++; $display("FAIL load_t0_stall[%0d] got=%b exp=%b", i, outs, 9'b1_00_00_00_00);
            end
            tick();
        end
        total++;
        if (outs !== 9'b0_11_00_00_00) begin
            bad++; $display("FAIL load_t0_release got=%b exp=%b", outs, 9'b0_11_00_00_00);
        end
        flush();
        // ALU consumer: needs the value in E
        drv(1, 0, 3, 0, 3, 1, 5, 2);
        tick();
        drv(1, 0, 3, 5, 1, 0, 0, 0);
        total++;
        if (outs !== 9'b1_00_00_00_00) begin
            bad++; $display("FAIL load_t1_stall got=%b exp=%b", outs, 9'b1_00_00_00_00);
        end
        tick();
        total++;
        if (outs !== 9'b0_00_00_00_00) begin
            bad++; $display("FAIL load_t1_release got=%b exp=%b", outs, 9'b0_00_00_00_00);
        end
        tick();
        idle();
        total++;
        if (outs !== 9'b0_00_00_00_11) begin
            bad++; $display("FAIL load_t1_e_fwd_w got=%b exp=%b", outs, 9'b0_00_00_00_11);
        end
        flush();
    endtask

    task automatic test_r0();
        drv(1, 0, 3, 0, 3, 1, 0, 2);
        tick();
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (outs !== 9'b0) begin
            bad++; $display("FAIL r0_no_hazard got=%b exp=%b", outs, 9'b0);
        end
        flush();
    endtask

    task automatic test_back_to_back();
        drv(1, 0, 3, 0, 3, 1, 7, 0);
        tick();
        tick();
        drv(1, 7, 0, 7, 0, 0, 0, 0);
        total++;
        if (outs !== 9'b0_01_01_00_00) begin
            bad++; $display("FAIL b2b_youngest_fwd got=%b exp=%b", outs, 9'b0_01_01_00_00);
        end
        flush();
        // Younger writer not yet ready must win over an older ready one
        drv(1, 0, 3, 0, 3, 1, 7, 0);
        tick();
        drv(1, 0, 3, 0, 3, 1, 7, 1);
        tick();
        drv(1, 7, 0, 0, 3, 0, 0, 0);
        total++;
        if (outs !== 9'b1_00_00_00_00) begin
            bad++; $display("FAIL b2b_youngest_stall got=%b exp=%b", outs, 9'b1_00_00_00_00);
        end
        flush();
    endtask

    task automatic test_reset_mid_stall();
        drv(1, 0, 3, 0, 3, 1, 5, 2);
        tick();
        drv(1, 5, 0, 0, 3, 0, 0, 0);
        total++;
        if (outs !== 9'b1_00_00_00_00) begin
            bad++; $display("FAIL rst_mid_pre got=%b exp=%b", outs, 9'b1_00_00_00_00);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (outs !== 9'b0) begin
            bad++; $display("FAIL rst_mid_post got=%b exp=%b", outs, 9'b0);
        end
        flush();
    endtask

`ifdef MDU_STALL_EN
    task automatic test_mdu();
        md_start = 1'b1;
        d_md = 1'b1;
        drv(1, 0, 3, 0, 3, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (stall !== (i < 6)) begin
                bad++; $display("FAIL mdu_busy[%0d] got=%b exp=%b", i, stall, (i < 6));
            end
            tick();
            md_start = 1'b0;
            #1;
        end
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL mdu_rst got=%b exp=0", stall);
        end
        d_md = 1'b0;
        flush();
    endtask
`endif

    task automatic test_random();
        logic [8:0] ex;
        for (int i = 0; i < 400; i++) begin
`ifdef MDU_STALL_EN
            md_start = ($urandom_range(0, 15) == 0);
            d_md     = ($urandom_range(0, 3) == 0);
`endif
            drv($urandom_range(0, 7) != 0,
                5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                2'($urandom_range(0, 2)));
            ex = model_out();
            total++;
            if (outs !== ex) begin
                bad++; $display("FAIL random[%0d] got=%b exp=%b", i, outs, ex);
            end
            tick();
        end
`ifdef MDU_STALL_EN
        md_start = 1'b0;
        d_md = 1'b0;
`endif
        flush();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) h[i] = empty_ins();
`ifdef MDU_STALL_EN
        md_start = 1'b0;
        d_md = 1'b0;
`endif
        rst = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
        test_alu_use();
        test_load_use();
        test_r0();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef MDU_STALL_EN
        test_mdu();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
